// File: rtl/video_pkg.sv
// Shared types and constants for the video test-pattern transmitter.
package video_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_t;

  // Colour bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [RGB_W-1:0] BAR_TABLE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/pattern_gen.sv
// Combinational pixel colour generator for the four test patterns.
module pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280
) (
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [1:0]       pat,
  input  logic [RGB_W-1:0] solid,
  output logic [RGB_W-1:0] rgb_c
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [RGB_W-1:0] bar_rgb;
  logic             bar_hit;
  logic             unused_y;

  // Only the checkerboard cell bit of y matters
  assign unused_y = ^{y[CNT_W-1:4], y[2:0]};

  // Bar lookup: first constant boundary above x wins; remainder pixels stay black
  always_comb begin
    bar_rgb = '0;
    bar_hit = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!bar_hit && (32'(x) < BAR_W * (i + 1))) begin
        bar_rgb = BAR_TABLE[3'(i)];
        bar_hit = 1'b1;
      end
    end
  end

  // Pattern select
  always_comb begin
    rgb_c = '0;
    case (pattern_t'(pat))
      PAT_BARS:  rgb_c = bar_rgb;
      PAT_RAMP:  rgb_c = {3{x[7:0]}};
      PAT_CHECK: rgb_c = (x[3] ^ y[3]) ? '0 : '1;
      PAT_SOLID: rgb_c = solid;
      default:   rgb_c = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_tx.sv
// Video timing generator with selectable test pattern and registered outputs.
module video_pattern_tx
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [23:0] pixel_out,
  output logic [10:0] x_out,
  output logic [10:0] y_out,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [1:0]       pat_q;
  logic [RGB_W-1:0] solid_q;

  logic             h_last_c, v_last_c, frame_wrap_c, origin_c;
  logic [1:0]       pat_use_c;
  logic [RGB_W-1:0] solid_use_c, rgb_c;
  logic             active_c, de_c, hs_c, vs_c, fs_c;
  logic [CNT_W-1:0] x_c, y_c;
  logic [RGB_W-1:0] pix_c;

  assign h_last_c     = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last_c     = (v_cnt == CNT_W'(V_TOTAL - 1));
  assign frame_wrap_c = h_last_c && v_last_c;
  assign origin_c     = (h_cnt == '0) && (v_cnt == '0);

  // At the frame origin the live selection applies immediately and is latched for the frame
  assign pat_use_c   = origin_c ? pattern_sel : pat_q;
  assign solid_use_c = origin_c ? solid_rgb   : solid_q;

  pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern_gen (
    .x     (h_cnt),
    .y     (v_cnt),
    .pat   (pat_use_c),
    .solid (solid_use_c),
    .rgb_c (rgb_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: DRAIN finishes the frame unless en comes back
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = frame_wrap_c ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (en)                state_d = ST_RUN;
        else if (frame_wrap_c) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output next values from current counters (registered one clock later)
  always_comb begin
    active_c = (state_q != ST_IDLE);
    de_c     = active_c && (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    hs_c     = active_c && (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END));
    vs_c     = active_c && (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END));
    fs_c     = de_c && origin_c;
    x_c      = de_c ? h_cnt : '0;
    y_c      = de_c ? v_cnt : '0;
    pix_c    = de_c ? rgb_c : '0;
  end

  // Raster counters, held at the origin while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state_q == ST_IDLE || state_d == ST_IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Pattern latch, only updated at the frame origin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= '0;
      solid_q <= '0;
    end else if (origin_c) begin
      pat_q   <= pattern_sel;
      solid_q <= solid_rgb;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out      <= 1'b0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      frame_start <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      pixel_out   <= '0;
    end else begin
      de_out      <= de_c;
      hsync_out   <= hs_c;
      vsync_out   <= vs_c;
      frame_start <= fs_c;
      x_out       <= x_c;
      y_out       <= y_c;
      pixel_out   <= pix_c;
    end
  end

endmodule

// File: tb/tb_video_pattern_tx.sv
// Self-checking bench for video_pattern_tx with a small raster reference model.
module tb_video_pattern_tx;

  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic        de_out, hsync_out, vsync_out, frame_start;
  logic [23:0] pixel_out;
  logic [10:0] x_out, y_out;

  always #5 clk = ~clk;

  video_pattern_tx #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .pixel_out(pixel_out),
    .x_out(x_out), .y_out(y_out), .frame_start(frame_start)
  );

  typedef struct packed {
    logic        de, hs, vs, fs;
    logic [10:0] x, y;
    logic [23:0] pix;
  } vid_t;

  typedef struct {
    logic        en;
    logic [1:0]  pat;
    logic [23:0] solid;
    int          cycles;
    int          de, fs, hs, vs, solid_n;
  } seg_t;

  int checks = 0;
  int failures = 0;

  // Reference model state: running flag, drain flag, position within the frame, latched pattern
  bit          m_active = 1'b0;
  bit          m_drain = 1'b0;
  int          m_pos = 0;
  logic [1:0]  m_pat = 2'd0;
  logic [23:0] m_solid = 24'h0;
  vid_t        exp_v = '0;

  int n_de, n_fs, n_hs, n_vs, n_solid;

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic vid_t ref_out(input int pos, input logic [1:0] pat, input logic [23:0] solid);
    vid_t r;
    int h, v, bar;
    r = '0;
    h = pos % H_TOTAL;
    v = pos / H_TOTAL;
    r.de = (h < H_ACTIVE) && (v < V_ACTIVE);
    r.hs = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
    r.vs = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
    r.fs = (pos == 0);
    if (r.de) begin
      r.x = 11'(h);
      r.y = 11'(v);
      case (pat)
        2'd0: begin
          bar = h / (H_ACTIVE / 8);
          r.pix = (bar < 8) ? bar_colour(bar) : 24'h0;
        end
        2'd1: r.pix = {3{8'(h)}};
        2'd2: r.pix = (((h / 8) + (v / 8)) % 2 == 0) ? 24'hFFFFFF : 24'h0;
        default: r.pix = solid;
      endcase
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_edge();
    logic [1:0]  p;
    logic [23:0] s;
    bit          last;
    p = (m_pos == 0) ? pattern_sel : m_pat;
    s = (m_pos == 0) ? solid_rgb : m_solid;
    exp_v = m_active ? ref_out(m_pos, p, s) : vid_t'('0);
    if (m_pos == 0) begin
      m_pat = pattern_sel;
      m_solid = solid_rgb;
    end
    if (!m_active) begin
      if (en) m_active = 1'b1;
    end else begin
      last = (m_pos == FRAME - 1);
      if (m_drain && en) m_drain = 1'b0;
      else if (!en && last) begin
        m_active = 1'b0;
        m_drain = 1'b0;
      end else if (!en) m_drain = 1'b1;
      m_pos = last ? 0 : m_pos + 1;
    end
  endtask

  function automatic vid_t actual();
    return {de_out, hsync_out, vsync_out, frame_start, x_out, y_out, pixel_out};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // One clock: model at the edge, compare on the falling edge
  task automatic cycle();
    vid_t a;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    a = actual();
    chk("raster", 64'(a), 64'(exp_v));
    n_de += int'(de_out);
    n_fs += int'(frame_start);
    n_hs += int'(hsync_out);
    n_vs += int'(vsync_out);
    n_solid += int'(de_out && pixel_out == 24'h123456);
  endtask

  seg_t segs [11];

  initial begin
    // en, pat, solid, cycles, de, fs, hs, vs, solid count
    segs[0]  = '{1'b1, 2'd0, 24'h0,      129, 32, 1, 24, 32, 0};
    segs[1]  = '{1'b1, 2'd0, 24'h0,       40, 24, 1,  6,  0, 0};
    segs[2]  = '{1'b1, 2'd3, 24'h123456,  88,  8, 0, 18, 32, 0};
    segs[3]  = '{1'b1, 2'd3, 24'h123456, 128, 32, 1, 24, 32, 32};
    segs[4]  = '{1'b1, 2'd1, 24'h123456,  20, 12, 1,  3,  0, 0};
    segs[5]  = '{1'b0, 2'd1, 24'h123456, 108, 20, 0, 21, 32, 0};
    segs[6]  = '{1'b0, 2'd1, 24'h123456,  10,  0, 0,  0,  0, 0};
    segs[7]  = '{1'b1, 2'd2, 24'h0,        1,  0, 0,  0,  0, 0};
    segs[8]  = '{1'b1, 2'd2, 24'h0,       20, 12, 1,  3,  0, 0};
    segs[9]  = '{1'b0, 2'd2, 24'h0,       76, 20, 0, 15, 16, 0};
    segs[10] = '{1'b1, 2'd2, 24'h0,       52, 12, 1,  9, 16, 0};

    // Reset state
    #12;
    chk("rst_state", 64'(actual()), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scripted segments with per-segment event counts
    for (int i = 0; i < 11; i++) begin
      en = segs[i].en;
      pattern_sel = segs[i].pat;
      solid_rgb = segs[i].solid;
      n_de = 0; n_fs = 0; n_hs = 0; n_vs = 0; n_solid = 0;
      for (int c = 0; c < segs[i].cycles; c++) cycle();
      chk($sformatf("seg%0d_de", i), 64'(n_de), 64'(segs[i].de));
      chk($sformatf("seg%0d_fs", i), 64'(n_fs), 64'(segs[i].fs));
      chk($sformatf("seg%0d_hs", i), 64'(n_hs), 64'(segs[i].hs));
      chk($sformatf("seg%0d_vs", i), 64'(n_vs), 64'(segs[i].vs));
      chk($sformatf("seg%0d_solid", i), 64'(n_solid), 64'(segs[i].solid_n));
    end

    // Run to h=5, v=2 then pulse reset between edges
    for (int c = 0; c < 17; c++) cycle();
    chk("pre_rst_de", 64'(de_out), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 64'(actual()), 64'h0);
    m_active = 1'b0; m_drain = 1'b0; m_pos = 0; m_pat = 2'd0; m_solid = 24'h0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", 64'(actual()), 64'h0);
    rst_n = 1'b1;
    en = 1'b1;
    cycle();
    cycle();
    chk("post_rst_fs", 64'({frame_start, de_out, x_out, y_out}), 64'({1'b1, 1'b1, 11'd0, 11'd0}));
    for (int c = 0; c < FRAME - 1; c++) cycle();

    // Randomised run/drain/pattern activity against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) begin
        pattern_sel = 2'($urandom);
        solid_rgb = 24'($urandom);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
